// File: rtl/video_stream_gen_pkg.sv
// Shared definitions for the video_stream_gen test-pattern source.
//   - state_t     : generator FSM states
//   - PAT_*       : pattern_sel_i codes
//   - LFSR_SEED / LFSR_TAPS and lfsr_step(): PRBS generator definition
//     (x^16+x^14+x^13+x^11+1, right-shifting Fibonacci form)
package video_stream_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LINE = 2'd1,
        HGAP = 2'd2,
        VGAP = 2'd3
    } state_t;

    localparam logic [2:0] PAT_FLAT  = 3'd0;
    localparam logic [2:0] PAT_HRAMP = 3'd1;
    localparam logic [2:0] PAT_VRAMP = 3'd2;
    localparam logic [2:0] PAT_CHECK = 3'd3;
    localparam logic [2:0] PAT_PRBS  = 3'd4;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Bits 0,2,3,5 of the right-shifting register realise taps 16,14,13,11.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

endpackage

// File: rtl/video_stream_gen_lfsr.sv
// 16-bit PRBS register for the pattern-4 output of video_stream_gen.
// Ports:
//   clk, rst      clock / asynchronous active-high reset
//   load_i        reload LFSR_SEED (wins over advance_i)
//   advance_i     step the register once
//   lfsr_o        low OUT_W bits of the current register value
module video_stream_gen_lfsr
    import video_stream_gen_pkg::*;
#(
    parameter int OUT_W = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             advance_i,
    output logic [OUT_W-1:0] lfsr_o
);

    logic [15:0] lfsr_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_reg <= '0;
        end else if (load_i) begin
            lfsr_reg <= LFSR_SEED;
        end else if (advance_i) begin
            lfsr_reg <= lfsr_step(lfsr_reg);
        end
    end

    assign lfsr_o = lfsr_reg[OUT_W-1:0];

endmodule

// File: rtl/video_stream_gen.sv
// Test-frame source for the do/de/hs/vs pixel stream.
// Emits (line_size_i+1) x (line_count_i+1) frames of a selectable pattern,
// with SPARSE_OUTPUT idle cycles after every pixel, max(hgap_i,1) idle
// cycles between lines and max(vgap_i,1) idle cycles after each frame.
// Optional feature: define VIDEO_STREAM_GEN_PRBS_EN to build the pattern-4
// PRBS generator; without it pattern 4 outputs 0.
// Ports:
//   clk, rst          clock / asynchronous active-high reset
//   en_i              run enable, sampled only at frame boundaries
//   pattern_sel_i     pattern code, latched at frame start
//   line_size_i       pixels per line minus 1 (latched)
//   line_count_i      lines per frame minus 1 (latched)
//   hgap_i, vgap_i    line / frame gap lengths (latched)
//   do_o, de_o        pixel data and valid
//   hs_o, vs_o        first pixel of line / frame (only with de_o)
//   frame_done_o      one-cycle pulse the cycle after the last pixel
//   busy_o            generator not idle
module video_stream_gen
    import video_stream_gen_pkg::*;
#(
    parameter int PIXEL_WIDTH   = 12,
    parameter int SPARSE_OUTPUT = 0,
    parameter int CNT_WIDTH     = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en_i,
    input  logic [2:0]             pattern_sel_i,
    input  logic [CNT_WIDTH-1:0]   line_size_i,
    input  logic [CNT_WIDTH-1:0]   line_count_i,
    input  logic [CNT_WIDTH-1:0]   hgap_i,
    input  logic [CNT_WIDTH-1:0]   vgap_i,
    output logic [PIXEL_WIDTH-1:0] do_o,
    output logic                   de_o,
    output logic                   hs_o,
    output logic                   vs_o,
    output logic                   frame_done_o,
    output logic                   busy_o
);

    localparam int SP_W = (SPARSE_OUTPUT > 0) ? $clog2(SPARSE_OUTPUT + 1) : 1;
    localparam logic [SP_W-1:0]      SP_LAST = SP_W'(SPARSE_OUTPUT);
    localparam logic [SP_W-1:0]      SP_ONE  = SP_W'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t                 state_reg, state_next;
    logic [CNT_WIDTH-1:0]   x_reg, x_next, y_reg, y_next, gap_reg, gap_next;
    logic [CNT_WIDTH-1:0]   ls_reg, ls_next, lc_reg, lc_next;
    logic [CNT_WIDTH-1:0]   hg_reg, hg_next, vg_reg, vg_next;
    logic [2:0]             pat_reg, pat_next;
    logic [SP_W-1:0]        sparse_reg, sparse_next;
    logic [PIXEL_WIDTH-1:0] do_reg, do_next, pix_val, x_pix, y_pix;
    logic de_reg, de_next, hs_reg, hs_next, vs_reg, vs_next;
    logic done_pend_reg, frame_done_reg, busy_reg, busy_next;
    logic emit, last_px, start_frame;
    logic [CNT_WIDTH-1:0]   hgap_last, vgap_last;

    // A zero gap still costs one idle cycle.
    assign hgap_last = (hg_reg == '0) ? '0 : hg_reg - CNT_ONE;
    assign vgap_last = (vg_reg == '0) ? '0 : vg_reg - CNT_ONE;

    // Ramps take the low PIXEL_WIDTH bits of the counters (they wrap).
    generate
        if (CNT_WIDTH >= PIXEL_WIDTH) begin : g_pix_trunc
            assign x_pix = x_reg[PIXEL_WIDTH-1:0];
            assign y_pix = y_reg[PIXEL_WIDTH-1:0];
        end else begin : g_pix_ext
            assign x_pix = {{(PIXEL_WIDTH-CNT_WIDTH){1'b0}}, x_reg};
            assign y_pix = {{(PIXEL_WIDTH-CNT_WIDTH){1'b0}}, y_reg};
        end
    endgenerate

`ifdef VIDEO_STREAM_GEN_PRBS_EN
    logic [PIXEL_WIDTH-1:0] prbs_pix;

    // Seeded on every frame start; the pixel uses the current value and
    // the register steps on the same edge that registers that pixel.
    video_stream_gen_lfsr #(
        .OUT_W(PIXEL_WIDTH)
    ) u_lfsr (
        .clk       (clk),
        .rst       (rst),
        .load_i    (start_frame),
        .advance_i (emit),
        .lfsr_o    (prbs_pix)
    );
`endif

    always_comb begin
        pix_val = '0;
        case (pat_reg)
            PAT_FLAT:  pix_val = {1'b1, {(PIXEL_WIDTH-1){1'b0}}};
            PAT_HRAMP: pix_val = x_pix;
            PAT_VRAMP: pix_val = y_pix;
            PAT_CHECK: pix_val = (x_reg[3] ^ y_reg[3]) ? '1 : '0;
`ifdef VIDEO_STREAM_GEN_PRBS_EN
            PAT_PRBS:  pix_val = prbs_pix;
`else
            PAT_PRBS:  pix_val = '0;
`endif
            default:   pix_val = '0;
        endcase
    end

    always_comb begin
        state_next  = state_reg;
        x_next      = x_reg;
        y_next      = y_reg;
        gap_next    = gap_reg;
        sparse_next = sparse_reg;
        ls_next     = ls_reg;
        lc_next     = lc_reg;
        hg_next     = hg_reg;
        vg_next     = vg_reg;
        pat_next    = pat_reg;
        emit        = 1'b0;
        last_px     = 1'b0;
        start_frame = 1'b0;

        case (state_reg)
            IDLE: begin
                if (en_i) begin
                    start_frame = 1'b1;
                    state_next  = LINE;
                end
            end
            LINE: begin
                if (sparse_reg == SP_LAST) begin
                    emit        = 1'b1;
                    sparse_next = '0;
                    if (x_reg == ls_reg) begin
                        x_next   = '0;
                        gap_next = '0;
                        if (y_reg == lc_reg) begin
                            y_next     = '0;
                            last_px    = 1'b1;
                            state_next = VGAP;
                        end else begin
                            y_next     = y_reg + CNT_ONE;
                            state_next = HGAP;
                        end
                    end else begin
                        x_next = x_reg + CNT_ONE;
                    end
                end else begin
                    sparse_next = sparse_reg + SP_ONE;
                end
            end
            HGAP: begin
                if (gap_reg == hgap_last) begin
                    gap_next   = '0;
                    state_next = LINE;
                end else begin
                    gap_next = gap_reg + CNT_ONE;
                end
            end
            VGAP: begin
                if (gap_reg == vgap_last) begin
                    gap_next = '0;
                    if (en_i) begin
                        start_frame = 1'b1;
                        state_next  = LINE;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    gap_next = gap_reg + CNT_ONE;
                end
            end
            default: state_next = IDLE;
        endcase

        // Frame configuration is frozen from here until the next frame start.
        if (start_frame) begin
            ls_next     = line_size_i;
            lc_next     = line_count_i;
            hg_next     = hgap_i;
            vg_next     = vgap_i;
            pat_next    = pattern_sel_i;
            x_next      = '0;
            y_next      = '0;
            sparse_next = '0;
        end
    end

    assign de_next   = emit;
    assign hs_next   = emit && (x_reg == '0);
    assign vs_next   = hs_next && (y_reg == '0);
    assign do_next   = emit ? pix_val : '0;
    assign busy_next = (state_next != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            x_reg          <= '0;
            y_reg          <= '0;
            gap_reg        <= '0;
            sparse_reg     <= '0;
            ls_reg         <= '0;
            lc_reg         <= '0;
            hg_reg         <= '0;
            vg_reg         <= '0;
            pat_reg        <= '0;
            do_reg         <= '0;
            de_reg         <= 1'b0;
            hs_reg         <= 1'b0;
            vs_reg         <= 1'b0;
            done_pend_reg  <= 1'b0;
            frame_done_reg <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            x_reg          <= x_next;
            y_reg          <= y_next;
            gap_reg        <= gap_next;
            sparse_reg     <= sparse_next;
            ls_reg         <= ls_next;
            lc_reg         <= lc_next;
            hg_reg         <= hg_next;
            vg_reg         <= vg_next;
            pat_reg        <= pat_next;
            do_reg         <= do_next;
            de_reg         <= de_next;
            hs_reg         <= hs_next;
            vs_reg         <= vs_next;
            // Delayed one extra stage so the pulse follows the last pixel.
            done_pend_reg  <= last_px;
            frame_done_reg <= done_pend_reg;
            busy_reg       <= busy_next;
        end
    end

    assign do_o         = do_reg;
    assign de_o         = de_reg;
    assign hs_o         = hs_reg;
    assign vs_o         = vs_reg;
    assign frame_done_o = frame_done_reg;
    assign busy_o       = busy_reg;

endmodule

// File: tb/tb_video_stream_gen.sv
// Bench for video_stream_gen: instance 0 with back-to-back pixels,
// instance 1 with SPARSE_OUTPUT=2. A frame-level model queues the expected
// pixels (value, hs, vs, idle gap before the pixel, last-of-frame) and a
// single negedge process checks both instances every cycle.
module tb_video_stream_gen;

    localparam int PW   = 12;
    localparam int MAXV = (1 << PW) - 1;

    typedef struct packed {
        logic [15:0] data;
        logic        hs;
        logic        vs;
        logic        last;
        int          gap;
    } exp_t;

    logic        clk, rst, en0, en1;
    logic [2:0]  pat_sel;
    logic [15:0] line_size, line_count, hgap, vgap;
    logic [PW-1:0] do0, do1;
    logic de0, hs0, vs0, fd0, busy0, de1, hs1, vs1, fd1, busy1;

    exp_t q0[$], q1[$], log0[$], log1[$];
    int idle[2], popped[2], done_exp[2];
    int total = 0, bad = 0;

    video_stream_gen #(.PIXEL_WIDTH(PW), .SPARSE_OUTPUT(0), .CNT_WIDTH(16)) u_dut0 (
        .clk(clk), .rst(rst), .en_i(en0), .pattern_sel_i(pat_sel),
        .line_size_i(line_size), .line_count_i(line_count), .hgap_i(hgap), .vgap_i(vgap),
        .do_o(do0), .de_o(de0), .hs_o(hs0), .vs_o(vs0), .frame_done_o(fd0), .busy_o(busy0));

    video_stream_gen #(.PIXEL_WIDTH(PW), .SPARSE_OUTPUT(2), .CNT_WIDTH(16)) u_dut1 (
        .clk(clk), .rst(rst), .en_i(en1), .pattern_sel_i(pat_sel),
        .line_size_i(line_size), .line_count_i(line_count), .hgap_i(hgap), .vgap_i(vgap),
        .do_o(do1), .de_o(de1), .hs_o(hs1), .vs_o(vs1), .frame_done_o(fd1), .busy_o(busy1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected frame, straight from the pattern and timing rules.
    task automatic push_frame(input int d, input int pat, input int ls, input int lc,
                              input int hg, input int vg, input bit first);
        logic [15:0] lf = 16'hACE1;
        int sp = (d == 0) ? 0 : 2;
        exp_t e;
        for (int y = 0; y <= lc; y++) begin
            for (int x = 0; x <= ls; x++) begin
                int v;
                case (pat)
                    0: v = 1 << (PW - 1);
                    1: v = x % (1 << PW);
                    2: v = y % (1 << PW);
                    3: v = (((x / 8) % 2) != ((y / 8) % 2)) ? MAXV : 0;
`ifdef VIDEO_STREAM_GEN_PRBS_EN
                    4: v = int'(lf) & MAXV;
`endif
                    default: v = 0;
                endcase
                lf = {lf[0] ^ lf[2] ^ lf[3] ^ lf[5], lf[15:1]};
                e.data = 16'(v);
                e.hs   = (x == 0);
                e.vs   = (x == 0 && y == 0);
                e.last = (x == ls && y == lc);
                if (x == 0 && y == 0) e.gap = first ? -1 : ((vg < 1 ? 1 : vg) + sp);
                else if (x == 0)      e.gap = (hg < 1 ? 1 : hg) + sp;
                else                  e.gap = sp;
                if (d == 0) q0.push_back(e); else q1.push_back(e);
            end
        end
    endtask

    task automatic observe(input int d, input logic de, input logic hs, input logic vs,
                           input logic fd, input logic busy, input logic [PW-1:0] dat);
        exp_t e, o;
        bit have = 0;
        if (rst) return;
        chk($sformatf("d%0d_frame_done", d), 32'(fd), 32'(done_exp[d]));
        done_exp[d] = 0;
        if (de) begin
            chk($sformatf("d%0d_busy_with_de", d), 32'(busy), 32'd1);
            if (d == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1; end
            if (d == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1; end
            if (!have) begin
                total++; bad++;
                $display("FAIL d%0d_unexpected_pixel actual=%0h required=none at %0t", d, dat, $time);
            end else begin
                chk($sformatf("d%0d_pix%0d_data", d, popped[d]), 32'(dat), 32'(e.data));
                chk($sformatf("d%0d_pix%0d_hs", d, popped[d]), 32'(hs), 32'(e.hs));
                chk($sformatf("d%0d_pix%0d_vs", d, popped[d]), 32'(vs), 32'(e.vs));
                if (e.gap >= 0) chk($sformatf("d%0d_pix%0d_gap", d, popped[d]), 32'(idle[d]), 32'(e.gap));
                done_exp[d] = int'(e.last);
                popped[d]++;
                o = e; o.data = 16'(dat); o.hs = hs; o.vs = vs; o.gap = idle[d];
                if (d == 0) log0.push_back(o); else log1.push_back(o);
            end
            idle[d] = 0;
        end else begin
            chk($sformatf("d%0d_idle_outputs", d), {29'd0, hs, vs, |dat}, 32'd0);
            idle[d]++;
        end
    endtask

    always @(negedge clk) begin
        observe(0, de0, hs0, vs0, fd0, busy0, do0);
        observe(1, de1, hs1, vs1, fd1, busy1, do1);
    end

    task automatic wait_popped(input int d, input int n);
        int c = 0;
        while (popped[d] < n && c < 5000) begin @(posedge clk); #1; c++; end
        if (popped[d] < n) begin
            total++; bad++;
            $display("FAIL d%0d_wait_pixels actual=%0d required=%0d", d, popped[d], n);
        end
    endtask

    task automatic wait_empty(input int d);
        int c = 0;
        while (((d == 0 ? q0.size() : q1.size()) != 0 || done_exp[d] != 0) && c < 5000) begin
            @(posedge clk); #1; c++;
        end
        chk($sformatf("d%0d_queue_drained", d), 32'(d == 0 ? q0.size() : q1.size()), 32'd0);
    endtask

    // Runs nfr frames, dropping en after drop_at pixels have appeared, then
    // scrambles the config inputs to show the latched values are used.
    task automatic run(input int d, input int nfr, input int drop_at, input int pat,
                       input int ls, input int lc, input int hg, input int vg);
        pat_sel = 3'(pat); line_size = 16'(ls); line_count = 16'(lc);
        hgap = 16'(hg); vgap = 16'(vg);
        popped[d] = 0;
        if (d == 0) log0.delete(); else log1.delete();
        for (int f = 0; f < nfr; f++) push_frame(d, pat, ls, lc, hg, vg, f == 0);
        if (d == 0) en0 = 1'b1; else en1 = 1'b1;
        wait_popped(d, drop_at);
        if (d == 0) en0 = 1'b0; else en1 = 1'b0;
        pat_sel = 3'd0; line_size = 16'd7; line_count = 16'd9; hgap = 16'd5; vgap = 16'd0;
        wait_empty(d);
        repeat (vg + hg + 8) @(posedge clk);
        #1;
        chk($sformatf("d%0d_busy_after_run", d), 32'(d == 0 ? busy0 : busy1), 32'd0);
    endtask

    initial begin
        logic [PW-1:0] prbs_first;
`ifdef VIDEO_STREAM_GEN_PRBS_EN
        prbs_first = 12'hCE1;
`else
        prbs_first = 12'h000;
`endif
        rst = 1'b1; en0 = 1'b0; en1 = 1'b0;
        pat_sel = 3'd0; line_size = 16'd0; line_count = 16'd0; hgap = 16'd0; vgap = 16'd0;
        for (int i = 0; i < 2; i++) begin idle[i] = 0; popped[i] = 0; done_exp[i] = 0; end
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs_d0", {25'd0, de0, hs0, vs0, fd0, busy0, |do0}, 32'd0);
        chk("reset_outputs_d1", {25'd0, de1, hs1, vs1, fd1, busy1, |do1}, 32'd0);
        rst = 1'b0;

        // 4x2 horizontal ramp, two frames
        run(0, 2, 9, 1, 3, 1, 2, 3);
        chk("t1_pixel_count", 32'(log0.size()), 32'd16);
        begin
            int t1_do[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
            for (int i = 0; i < 8; i++) chk($sformatf("t1_do_%0d", i), 32'(log0[i].data), 32'(t1_do[i]));
        end
        chk("t1_hs_1st", 32'(log0[0].hs), 32'd1);
        chk("t1_hs_5th", 32'(log0[4].hs), 32'd1);
        chk("t1_hs_2nd", 32'(log0[1].hs), 32'd0);
        chk("t1_vs_5th", 32'(log0[4].vs), 32'd0);
        chk("t1_hgap_idle", 32'(log0[4].gap), 32'd2);
        chk("t1_vgap_idle", 32'(log0[8].gap), 32'd3);
        chk("t1_frame2_vs", 32'(log0[8].vs), 32'd1);

        // sparse instance, 4x1 frame
        run(1, 1, 1, 1, 3, 0, 1, 1);
        chk("t2_pixel_count", 32'(log1.size()), 32'd4);
        chk("t2_spacing", 32'(log1[2].gap), 32'd2);
        chk("t2_first_hsvs", {30'd0, log1[0].hs, log1[0].vs}, 32'd3);
        chk("t2_last_hsvs", {30'd0, log1[3].hs, log1[3].vs}, 32'd0);

        // 16x16 checker
        run(0, 1, 1, 3, 15, 15, 1, 1);
        chk("t3_px_8_0", 32'(log0[8].data), 32'(MAXV));
        chk("t3_px_0_8", 32'(log0[128].data), 32'(MAXV));
        chk("t3_px_8_8", 32'(log0[136].data), 32'd0);
        chk("t3_px_0_0", 32'(log0[0].data), 32'd0);

        // en dropped at pixel 3 of line 0 in a 4x4 frame
        run(0, 1, 4, 2, 3, 3, 1, 2);
        chk("t4_pixel_count", 32'(log0.size()), 32'd16);
        chk("t4_last_line_val", 32'(log0[15].data), 32'd3);

        // asynchronous reset in the middle of a line
        pat_sel = 3'd1; line_size = 16'd3; line_count = 16'd1; hgap = 16'd2; vgap = 16'd3;
        popped[0] = 0;
        push_frame(0, 1, 3, 1, 2, 3, 1'b1);
        en0 = 1'b1;
        wait_popped(0, 2);
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("t5_async_clear", {27'd0, de0, hs0, vs0, busy0, |do0}, 32'd0);
        q0.delete(); log0.delete();
        idle[0] = 0; popped[0] = 0; done_exp[0] = 0;
        push_frame(0, 1, 3, 1, 2, 3, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        wait_popped(0, 1);
        en0 = 1'b0;
        chk("t5_first_hsvs", {30'd0, log0[0].hs, log0[0].vs}, 32'd3);
        wait_empty(0);
        repeat (10) @(posedge clk);
        #1;
        chk("t5_busy_after", 32'(busy0), 32'd0);

        // pattern 4, two 4x2 frames
        run(0, 2, 9, 4, 3, 1, 1, 1);
        chk("t6_first_f1", 32'(log0[0].data), 32'(prbs_first));
        chk("t6_first_f2", 32'(log0[8].data), 32'(prbs_first));
        for (int i = 1; i < 8; i++) chk($sformatf("t6_repeat_%0d", i), 32'(log0[8 + i].data), 32'(log0[i].data));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/video_stream_gen.md
Name: video_stream_gen

Overview:
- Source (transmitter) of the team's pixel stream interface: `do_o`/`de_o`/`hs_o`/`vs_o`.
- `de_o` qualifies each pixel. `hs_o` and `vs_o` are only valid while `de_o` is high.
- `hs_o` marks the first pixel of every line; `vs_o` marks the first pixel of a frame.
- Generates programmable-size test frames with configurable pixel sparsity and line/frame gaps. Feeds `scaler_v`/`scaler_h` chains in simulation and on-board bring-up.

Parameters:
- `PIXEL_WIDTH`, 12, pixel bit width (4..16).
- `SPARSE_OUTPUT`, 0, idle cycles inserted after each emitted pixel (0 = back-to-back).
- `CNT_WIDTH`, 16, width of the x, y and gap counters.

Ports:
- `clk`  in  1  sole clock.
- `rst`  in  1  asynchronous reset, active-high.
- `en_i`  in  1  run enable; sampled at frame boundaries.
- `pattern_sel_i`  in  3  pattern code; sampled at frame start.
- `line_size_i`  in  `CNT_WIDTH`  pixels per line minus 1.
- `line_count_i`  in  `CNT_WIDTH`  lines per frame minus 1.
- `hgap_i`  in  `CNT_WIDTH`  idle cycles between lines (min 1 is enforced).
- `vgap_i`  in  `CNT_WIDTH`  idle cycles after a frame (min 1 is enforced).
- `do_o`  out  `PIXEL_WIDTH`  pixel data.
- `de_o`  out  1  pixel valid.
- `hs_o`  out  1  first pixel of line (only with `de_o`).
- `vs_o`  out  1  first pixel of frame (only with `de_o`).
- `frame_done_o`  out  1  one-cycle pulse after the last pixel of a frame.
- `busy_o`  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0. Asynchronous assertion clears outputs immediately, including mid-line. No partial frame resumes after reset.
- All outputs are registered. A pixel appears on `do_o` in the cycle after the FSM decides to emit it.
- FSM states:
  - IDLE: when `en_i`=1, latch `line_size_i`, `line_count_i`, `hgap_i`, `vgap_i`, `pattern_sel_i`; x=0, y=0, `sparse_cnt`=0; go to LINE. Inputs are held constant for the whole frame regardless of input changes.
  - LINE:
    - `sparse_cnt` counts 0..`SPARSE_OUTPUT`. On `sparse_cnt`==`SPARSE_OUTPUT`, emit a pixel: `de_o`=1, `hs_o`=(x==0), `vs_o`=(x==0 && y==0). Then x++ and `sparse_cnt`=0.
    - When x==`line_size` is emitted: if y==`line_count`, go to VGAP and pulse `frame_done_o` the next cycle. Otherwise y++, x=0, go to HGAP.
  - HGAP: `de_o`=0 for max(`hgap`,1) cycles, then LINE.
  - VGAP: `de_o`=0 for max(`vgap`,1) cycles. Then, if `en_i`=1, relatch the inputs and go to LINE (new frame); otherwise go to IDLE.
- `en_i` deassertion mid-frame does not truncate: the current frame completes including VGAP.
- Patterns, with `MAXV` = 2^`PIXEL_WIDTH`-1:
  - 0: flat mid-grey, 1<<(`PIXEL_WIDTH`-1).
  - 1: horizontal ramp, x[`PIXEL_WIDTH`-1:0] (wraps).
  - 2: vertical ramp, y[`PIXEL_WIDTH`-1:0].
  - 3: 8x8 checker, (x[3]^y[3]) ? `MAXV` : 0.
  - 4: PRBS (optional feature).
  - 5-7: `do_o`=0.
- `do_o` is 0 whenever `de_o`=0.
- `line_size`=0 gives 1-pixel lines with `hs_o` on every pixel. `line_count`=0 gives a 1-line frame, where `vs_o` and `hs_o` coincide.
- Counters do not saturate. Maximum frame is 2^`CNT_WIDTH` x 2^`CNT_WIDTH`.

Optional Feature:
- Macro: `VIDEO_STREAM_GEN_PRBS_EN`.
- Defined:
  - Pattern 4 outputs `lfsr[PIXEL_WIDTH-1:0]` of a 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1.
  - The LFSR is seeded with 16'hACE1 at every frame start and advances once per emitted pixel, after output.
- Undefined: pattern 4 outputs 0 and no LFSR logic is synthesized.

Decomposition:
- Package `video_stream_gen_pkg`:
  - FSM state constants IDLE/LINE/HGAP/VGAP.
  - Pattern codes `PAT_FLAT`, `PAT_HRAMP`, `PAT_VRAMP`, `PAT_CHECK`, `PAT_PRBS`.
  - `LFSR_SEED` and LFSR tap mask.
- Sub-module `video_stream_gen_lfsr`: LFSR with load/advance, instantiated only under the macro.

Test Plan:
- Frame 4x2, pattern 1, `SPARSE_OUTPUT`=0, `hgap`=2, `vgap`=3 -> 8 `de_o` cycles with `do_o` 0,1,2,3 per line. `hs_o` on the 1st and 5th pixel, `vs_o` only on the 1st. Exactly 2 idle cycles between lines. `frame_done_o` pulses once. Next frame's `vs_o` comes 3 idle cycles later.
- `SPARSE_OUTPUT`=2, 4x1 frame -> `de_o` high every 3rd cycle, 4 pixels total, `hs_o`/`vs_o` on the first only.
- Pattern 3, 16x16 frame -> pixel (8,0)=`MAXV`, (0,8)=`MAXV`, (8,8)=0, (0,0)=0.
- `en_i` dropped at pixel 3 of line 0 in a 4x4 frame -> all 16 pixels still emitted, then IDLE with `busy_o`=0. No new `vs_o` appears.
- `rst` asserted mid-line -> `de_o`/`hs_o`/`vs_o`/`do_o` are 0 without waiting for a clock edge. After release with `en_i`=1, the first pixel carries `vs_o`=1 and `hs_o`=1.
- With `VIDEO_STREAM_GEN_PRBS_EN`, pattern 4, `PIXEL_WIDTH`=12 -> first pixel of every frame = 12'hCE1 and successive frames are identical. Without the macro -> all pixels 0.
